pattern_pulse_generator: RTL and testbench



---
 rtl/pattern_pulse_generator.sv | 181 ++++++++++++++++++
 tb/tb_pattern_pulse_generator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_pulse_generator.sv
// pattern_pulse_generator
//   Serial pattern generator. A WIDTH-bit pattern is latched on load and
//   shifted out on a single line, one bit every P clocks (P = latched period,
//   0 treated as 1). Supports one-shot / continuous repeat, LSB- or
//   MSB-first order, abort via stop, and busy/done status.
//
//   state  | meaning
//   IDLE   | no run active, out held at IDLE_LEVEL
//   RUN    | emitting pattern bits, busy=1
//
// Ports:
//   clock        system clock, all logic on rising edge
//   reset        synchronous active-high reset
//   pattern      pattern to emit, sampled when load=1
//   load         start/restart request (has priority over stop)
//   period       clocks per bit, sampled with load
//   repeat_mode  1 = restart pattern after last bit, sampled with load
//   msb_first    1 = emit pattern[WIDTH-1] first, sampled with load
//   stop         abort request (ignored in IDLE)
//   out          registered serial bit
//   busy         high while in RUN
//   done         one-cycle pulse after the last bit of a one-shot run
//   bit_index    index of the bit currently on out (0 = first emitted)

module pattern_pulse_generator #(
  parameter int   WIDTH      = 16,
  parameter int   PERIOD_W   = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         pattern,
  input  logic                     load,
  input  logic [PERIOD_W-1:0]      period,
  input  logic                     repeat_mode,
  input  logic                     msb_first,
  input  logic                     stop,
  output logic                     out,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_index
);

  localparam int                IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]    shadow_q, shadow_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [PERIOD_W-1:0] prescale_q, prescale_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                repeat_q, repeat_d;
  logic                msb_q, msb_d;
  logic                out_q, out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [WIDTH-1:0]    shift_adv;
  logic                wrap;

  // The bit shown on out is always the one at the "head" of the shift
  // register: bit 0 for LSB-first, bit WIDTH-1 for MSB-first.
  function automatic logic head_bit(input logic [WIDTH-1:0] v, input logic msb);
    return msb ? v[WIDTH-1] : v[0];
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      shift_q    <= '0;
      prescale_q <= '0;
      period_q   <= '0;
      repeat_q   <= 1'b0;
      msb_q      <= 1'b0;
      out_q      <= IDLE_LEVEL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      shift_q    <= shift_d;
      prescale_q <= prescale_d;
      period_q   <= period_d;
      repeat_q   <= repeat_d;
      msb_q      <= msb_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    shift_d    = shift_q;
    prescale_d = prescale_q;
    period_d   = period_q;
    repeat_d   = repeat_q;
    msb_d      = msb_q;
    out_d      = out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    idx_d      = idx_q;

    shift_adv  = msb_q ? (shift_q << 1) : (shift_q >> 1);
    wrap       = (prescale_q == (period_q - PERIOD_W'(1)));

    if (load) begin
      // Restart from any state; an aborted run never reports done.
      shadow_d   = pattern;
      shift_d    = pattern;
      period_d   = (period == '0) ? PERIOD_W'(1) : period;
      repeat_d   = repeat_mode;
      msb_d      = msb_first;
      prescale_d = '0;
      idx_d      = '0;
      busy_d     = 1'b1;
      out_d      = head_bit(pattern, msb_first);
      state_d    = S_RUN;
    end else begin
      case (state_q)
        S_IDLE: begin
          out_d  = IDLE_LEVEL;
          busy_d = 1'b0;
        end
        S_RUN: begin
          if (stop) begin
            state_d    = S_IDLE;
            out_d      = IDLE_LEVEL;
            busy_d     = 1'b0;
            idx_d      = '0;
            prescale_d = '0;
          end else if (wrap) begin
            prescale_d = '0;
            if (idx_q == LAST_IDX) begin
              if (repeat_q) begin
                // Seamless wrap: bit 0 follows the last bit with no gap.
                shift_d = shadow_q;
                out_d   = head_bit(shadow_q, msb_q);
                idx_d   = '0;
              end else begin
                state_d = S_IDLE;
                out_d   = IDLE_LEVEL;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                idx_d   = '0;
              end
            end else begin
              shift_d = shift_adv;
              out_d   = head_bit(shift_adv, msb_q);
              idx_d   = idx_q + IDX_W'(1);
            end
          end else begin
            prescale_d = prescale_q + PERIOD_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          out_d   = IDLE_LEVEL;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bit_index = idx_q;

endmodule

// File: tb/tb_pattern_pulse_generator.sv
// Directed testbench for pattern_pulse_generator (WIDTH=16, PERIOD_W=8,
// IDLE_LEVEL=0). Inputs are driven and outputs sampled on the falling edge.
module tb_pattern_pulse_generator;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pattern;
  logic        load;
  logic [7:0]  period;
  logic        repeat_mode;
  logic        msb_first;
  logic        stop;
  logic        out;
  logic        busy;
  logic        done;
  logic [3:0]  bit_index;

  int passed = 0;
  int total  = 0;

  pattern_pulse_generator #(
    .WIDTH(16),
    .PERIOD_W(8),
    .IDLE_LEVEL(1'b0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pattern(pattern),
    .load(load),
    .period(period),
    .repeat_mode(repeat_mode),
    .msb_first(msb_first),
    .stop(stop),
    .out(out),
    .busy(busy),
    .done(done),
    .bit_index(bit_index)
  );

  always #5 clock = ~clock;

  // Stimulus only: present a load for one rising edge, return at the
  // falling edge where the first bit is visible.
  task automatic start(input logic [15:0] pat, input logic [7:0] per,
                       input logic rep, input logic msb);
    pattern     = pat;
    period      = per;
    repeat_mode = rep;
    msb_first   = msb;
    load        = 1'b1;
    @(negedge clock);
    load        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; stop = 1'b0; pattern = '0; period = '0;
    repeat_mode = 1'b0; msb_first = 1'b0;
    @(negedge clock);
    @(negedge clock);
    total++; if ({out, busy, done, bit_index} !== 7'b0) $display("FAIL reset_state got %b expected 0000000", {out, busy, done, bit_index}); else passed++;
    reset = 1'b0;
    @(negedge clock);
    total++; if ({out, busy, done} !== 3'b0) $display("FAIL after_reset_idle got %b expected 000", {out, busy, done}); else passed++;
  endtask

  task automatic test_oneshot_lsb();
    logic [15:0] seq;
    int errs = 0;
    seq = 16'b1010_0101_1100_0011; // emitted LSB first: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
    start(16'hA5C3, 8'd1, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clock);
      total++;
      if (out !== seq[c] || busy !== 1'b1 || done !== 1'b0 || bit_index !== 4'(c)) begin
        $display("FAIL lsb_p1 cycle %0d got out=%b busy=%b done=%b idx=%0d expected out=%b busy=1 done=0 idx=%0d",
                 c, out, busy, done, bit_index, seq[c], c);
      end else passed++;
    end
    @(negedge clock);
    total++; if (done !== 1'b1 || busy !== 1'b0 || out !== 1'b0) $display("FAIL lsb_p1_done got done=%b busy=%b out=%b expected 1 0 0", done, busy, out); else passed++;
    @(negedge clock);
    total++; if (done !== 1'b0) $display("FAIL lsb_p1_done_width got done=%b expected 0", done); else passed++;
  endtask

  task automatic test_msb_period3();
    logic [15:0] pat;
    pat = 16'hA5C3;
    start(pat, 8'd3, 1'b0, 1'b1);
    // Input changes during a run must have no effect.
    pattern = 16'h0000; period = 8'd1; msb_first = 1'b0; repeat_mode = 1'b1;
    for (int c = 0; c < 48; c++) begin
      if (c > 0) @(negedge clock);
      total++;
      if (out !== pat[15 - c/3] || busy !== 1'b1 || done !== 1'b0 || bit_index !== 4'(c/3)) begin
        $display("FAIL msb_p3 cycle %0d got out=%b busy=%b done=%b idx=%0d expected out=%b busy=1 done=0 idx=%0d",
                 c, out, busy, done, bit_index, pat[15 - c/3], c/3);
      end else passed++;
    end
    @(negedge clock);
    total++; if (done !== 1'b1 || busy !== 1'b0 || out !== 1'b0) $display("FAIL msb_p3_done got done=%b busy=%b out=%b expected 1 0 0", done, busy, out); else passed++;
    @(negedge clock);
    total++; if (done !== 1'b0) $display("FAIL msb_p3_done_width got done=%b expected 0", done); else passed++;
  endtask

  task automatic test_period0();
    logic [15:0] pat;
    pat = 16'h30F1;
    start(pat, 8'd0, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clock);
      total++;
      if (out !== pat[c] || busy !== 1'b1 || bit_index !== 4'(c)) begin
        $display("FAIL period0 cycle %0d got out=%b busy=%b idx=%0d expected out=%b busy=1 idx=%0d",
                 c, out, busy, bit_index, pat[c], c);
      end else passed++;
    end
    @(negedge clock);
    total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL period0_done got done=%b busy=%b expected 1 0", done, busy); else passed++;
  endtask

  task automatic test_repeat();
    logic exp_out;
    start(16'h0001, 8'd2, 1'b1, 1'b0);
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clock);
      exp_out = ((c % 32) < 2);
      total++;
      if (out !== exp_out || busy !== 1'b1 || done !== 1'b0 || bit_index !== 4'((c/2) % 16)) begin
        $display("FAIL repeat cycle %0d got out=%b busy=%b done=%b idx=%0d expected out=%b busy=1 done=0 idx=%0d",
                 c, out, busy, done, bit_index, exp_out, (c/2) % 16);
      end else passed++;
    end
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    total++; if ({out, busy, done} !== 3'b000) $display("FAIL repeat_stop got %b expected 000", {out, busy, done}); else passed++;
  endtask

  task automatic test_reload_midrun();
    start(16'hA5C3, 8'd2, 1'b0, 1'b0);
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clock);
      total++;
      if (bit_index !== 4'(c/2) || done !== 1'b0) $display("FAIL reload_first_run cycle %0d got idx=%0d done=%b expected idx=%0d done=0", c, bit_index, done, c/2); else passed++;
    end
    pattern = 16'hFFFF;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    for (int d = 0; d < 32; d++) begin
      if (d > 0) @(negedge clock);
      total++;
      if (out !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || bit_index !== 4'(d/2)) begin
        $display("FAIL reload_second_run cycle %0d got out=%b busy=%b done=%b idx=%0d expected out=1 busy=1 done=0 idx=%0d",
                 d, out, busy, done, bit_index, d/2);
      end else passed++;
    end
    @(negedge clock);
    total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL reload_done got done=%b busy=%b expected 1 0", done, busy); else passed++;
  endtask

  task automatic test_stop();
    logic [15:0] pat;
    pat = 16'hA5C3;
    start(pat, 8'd1, 1'b0, 1'b0);
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) @(negedge clock);
      total++;
      if (out !== pat[c] || bit_index !== 4'(c)) $display("FAIL stop_prerun cycle %0d got out=%b idx=%0d expected out=%b idx=%0d", c, out, bit_index, pat[c], c); else passed++;
    end
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    total++; if ({out, busy, done} !== 3'b000) $display("FAIL stop_abort got %b expected 000", {out, busy, done}); else passed++;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL stop_no_done cycle %0d got done=%b busy=%b expected 0 0", c, done, busy); else passed++;
    end
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    total++; if ({out, busy, done} !== 3'b000) $display("FAIL stop_in_idle got %b expected 000", {out, busy, done}); else passed++;
  endtask

  task automatic test_reset_midrun();
    start(16'hA5C3, 8'd2, 1'b0, 1'b1);
    repeat (5) @(negedge clock);
    total++; if (busy !== 1'b1) $display("FAIL reset_midrun_busy got %b expected 1", busy); else passed++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++; if ({out, busy, done, bit_index} !== 7'b0) $display("FAIL reset_midrun got %b expected 0000000", {out, busy, done, bit_index}); else passed++;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL reset_no_done cycle %0d got done=%b busy=%b expected 0 0", c, done, busy); else passed++;
    end
  endtask

  task automatic test_load_stop_same();
    pattern = 16'h8000; period = 8'd1; repeat_mode = 1'b0; msb_first = 1'b1;
    load = 1'b1; stop = 1'b1;
    @(negedge clock);
    load = 1'b0; stop = 1'b0;
    total++; if (busy !== 1'b1 || out !== 1'b1 || bit_index !== 4'd0) $display("FAIL load_beats_stop got busy=%b out=%b idx=%0d expected 1 1 0", busy, out, bit_index); else passed++;
    @(negedge clock);
    total++; if (out !== 1'b0 || bit_index !== 4'd1) $display("FAIL load_beats_stop_next got out=%b idx=%0d expected 0 1", out, bit_index); else passed++;
    repeat (15) @(negedge clock);
    total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL load_beats_stop_done got done=%b busy=%b expected 1 0", done, busy); else passed++;
  endtask

  task automatic test_load_held();
    pattern = 16'h0002; period = 8'd1; repeat_mode = 1'b0; msb_first = 1'b0;
    load = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      total++; if (out !== 1'b0 || bit_index !== 4'd0 || busy !== 1'b1) $display("FAIL load_held cycle %0d got out=%b idx=%0d busy=%b expected 0 0 1", c, out, bit_index, busy); else passed++;
    end
    load = 1'b0;
    @(negedge clock);
    total++; if (out !== 1'b1 || bit_index !== 4'd1) $display("FAIL load_release got out=%b idx=%0d expected 1 1", out, bit_index); else passed++;
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot_lsb();
    test_msb_period3();
    test_period0();
    test_repeat();
    test_reload_midrun();
    test_stop();
    test_reset_midrun();
    test_load_stop_same();
    test_load_held();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
